// File: rtl/control_sequencer_if.sv
// Bundles the signals between the microcode sequencer and its environment:
// the datapath (bus, flags, control word), the memory handshake and the
// microcode ROM (address out, combinational word back).
interface control_sequencer_if #(
  parameter int unsigned SIG_W = 42
) ();

  // Datapath and memory side
  logic [7:0]       bus;         // shared data bus, source of opcodes
  logic [3:0]       flags_in;    // ALU flags {C,Z,N,V}
  logic             mem_ready;   // waited memory access completes this cycle

  // Microcode ROM side
  logic [SIG_W+1:0] ucode_data;  // {HALT, END, signals}
  logic [15:0]      ucode_addr;  // {flags_q, ir, step}

  // Sequencer status and control word
  logic [SIG_W-1:0] signals;
  logic [7:0]       ir;
  logic [3:0]       step;
  logic             halted;
  logic             fault;

  // The sequencer itself
  modport master (
    input  bus, flags_in, mem_ready, ucode_data,
    output ucode_addr, signals, ir, step, halted, fault
  );

  // The datapath / ROM / memory model around it
  modport slave (
    output bus, flags_in, mem_ready, ucode_data,
    input  ucode_addr, signals, ir, step, halted, fault
  );

endinterface

// File: rtl/control_sequencer.sv
// Microcoded control sequencer. Each step, the ROM word addressed by
// {flags, opcode, step} is registered onto the control word. Bits of that
// registered word load the opcode, latch flags and request a memory wait.
// The ROM word's END bit restarts the step counter; its HALT bit stops the
// machine one step later. Running off step 15 without END is a fault.
module control_sequencer #(
  parameter int unsigned      SIG_W          = 42,
  parameter logic [SIG_W-1:0] IDLE_WORD      = '0,
  parameter int unsigned      IR_LOAD_IDX    = 0,
  parameter int unsigned      FLAGS_LOAD_IDX = 1,
  parameter int unsigned      WAIT_IDX       = 2
) (
  input logic                 clk,
  input logic                 reset,
  control_sequencer_if.master cs
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int unsigned END_BIT   = SIG_W;
  localparam int unsigned HALT_BIT  = SIG_W + 1;
  localparam logic [3:0]  LAST_STEP = 4'hF;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] signals_q, signals_d;
  logic [3:0]       step_q, step_d;
  logic [7:0]       ir_q, ir_d;
  logic [3:0]       flags_q, flags_d;
  logic             halt_pend_q, halt_pend_d;

  logic [SIG_W-1:0] rom_signals;
  logic             rom_end;
  logic             rom_halt;
  logic             stall;
  logic             advance;

  assign rom_signals = cs.ucode_data[SIG_W-1:0];
  assign rom_end     = cs.ucode_data[END_BIT];
  assign rom_halt    = cs.ucode_data[HALT_BIT];

  // The step currently on the control word asked to wait and memory is not
  // done yet: everything freezes. Only the RUN state ever advances.
  assign stall   = (state_q == ST_RUN) && signals_q[WAIT_IDX] && !cs.mem_ready;
  assign advance = (state_q == ST_RUN) && !stall;

  // Next-state and next-register computation for one non-stalled step.
  always_comb begin
    // NOTE: every value written below gets its hold value first, so no path
    // through the block leaves a variable unassigned and no latch is inferred.
    state_d     = state_q;
    signals_d   = signals_q;
    step_d      = step_q;
    ir_d        = ir_q;
    flags_d     = flags_q;
    halt_pend_d = halt_pend_q;

    if (advance) begin
      // Load strobes act on the word currently driven, so the new opcode and
      // flags only reach ucode_addr one cycle later.
      if (signals_q[IR_LOAD_IDX]) begin
        ir_d = cs.bus;
      end
      if (signals_q[FLAGS_LOAD_IDX]) begin
        flags_d = cs.flags_in;
      end

      if (halt_pend_q) begin
        // The HALT word has had its one cycle on the control word; the ROM
        // word now being presented is not consumed and step holds.
        state_d     = ST_HALT;
        signals_d   = IDLE_WORD;
        halt_pend_d = 1'b0;
      end else if (!rom_end && (step_q == LAST_STEP)) begin
        // Step counter would wrap: fault wins over a HALT bit in this word.
        state_d   = ST_FAULT;
        signals_d = IDLE_WORD;
      end else begin
        signals_d   = rom_signals;
        step_d      = rom_end ? 4'd0 : step_q + 4'd1;
        halt_pend_d = rom_halt;
      end
    end
  end

  // State and datapath-control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_RUN;
      signals_q   <= IDLE_WORD;
      step_q      <= 4'd0;
      ir_q        <= 8'd0;
      flags_q     <= 4'd0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      signals_q   <= signals_d;
      step_q      <= step_d;
      ir_q        <= ir_d;
      flags_q     <= flags_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign cs.ucode_addr = {flags_q, ir_q, step_q};
  assign cs.signals    = signals_q;
  assign cs.ir         = ir_q;
  assign cs.step       = step_q;
  assign cs.halted     = (state_q == ST_HALT);
  assign cs.fault      = (state_q == ST_FAULT);

endmodule
